// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the write-path interconnect blocks.
// Holds the write-path-lock FSM encoding and the AXI length and strobe widths.
package axi_ic_pkg;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wpl_state_e;

    function automatic int STRB_WIDTH(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_write_path_lock_if.sv
// Bundle of arbiter-side control, per-master AW/W and slave-side AW/W signals.
// Valid/ready: a transfer happens on a rising edge where both are high; the source holds valid and payload stable until then.
interface axi_write_path_lock_if #(
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import axi_ic_pkg::*;
    localparam int SW = STRB_WIDTH(DATA_WIDTH);

    logic                            channel_request;
    logic [ID_WIDTH-1:0]             selected_slave;
    logic                            channel_granted;
    logic                            lock_busy;
    logic [ID_WIDTH-1:0]             owner_id;
    logic                            sel_err;
    logic                            len_err;

    logic [NUM_REQ-1:0]              m_awvalid;
    logic [NUM_REQ-1:0]              m_awready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   m_awaddr;
    logic [NUM_REQ*AXI_LEN_WIDTH-1:0] m_awlen;
    logic [NUM_REQ-1:0]              m_wvalid;
    logic [NUM_REQ-1:0]              m_wready;
    logic [NUM_REQ*DATA_WIDTH-1:0]   m_wdata;
    logic [NUM_REQ*SW-1:0]           m_wstrb;
    logic [NUM_REQ-1:0]              m_wlast;

    logic                            s_awvalid;
    logic [ADDR_WIDTH-1:0]           s_awaddr;
    logic [AXI_LEN_WIDTH-1:0]        s_awlen;
    logic                            s_awready;
    logic                            s_wvalid;
    logic [DATA_WIDTH-1:0]           s_wdata;
    logic [SW-1:0]                   s_wstrb;
    logic                            s_wlast;
    logic                            s_wready;

    // Block-side view: sees masters and arbiter as inputs, drives the slave.
    modport slave (
        input  channel_request, selected_slave,
        output channel_granted, lock_busy, owner_id, sel_err, len_err,
        input  m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_awready, m_wready,
        output s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_awready, s_wready
    );

    // Environment view: arbiter, masters and downstream slave.
    modport master (
        output channel_request, selected_slave,
        input  channel_granted, lock_busy, owner_id, sel_err, len_err,
        output m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_awready, m_wready,
        input  s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_awready, s_wready
    );

endinterface

// File: rtl/axi_onehot_mux.sv
// Index-select mux: picks one W-bit slice out of N packed slices.
module axi_onehot_mux #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int SEL_W = 1
) (
    input  logic [N*W-1:0]   in_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [W-1:0]     out_o
);

    always_comb begin
        out_o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SEL_W'(i)) out_o = in_i[i*W +: W];
        end
    end

endmodule

// File: rtl/axi_write_path_lock.sv
// Locks the single slave AW+W path to the arbiter's chosen master for one burst,
// generating WLAST locally from a beat counter loaded with AWLEN.
module axi_write_path_lock
    import axi_ic_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axi_write_path_lock_if.slave  bus,
    output wpl_state_e            dbg_state_o
);

    localparam int SW   = STRB_WIDTH(DATA_WIDTH);
    localparam int AW_W = 1 + ADDR_WIDTH + AXI_LEN_WIDTH;
    localparam int W_W  = 2 + SW + DATA_WIDTH;
    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

    wpl_state_e               state_q;
    logic                     channel_granted_q;
    logic                     lock_busy_q;
    logic                     sel_err_q;
    logic                     len_err_q;
    logic [ID_WIDTH-1:0]      owner_q;
    logic [AXI_LEN_WIDTH-1:0] beat_cnt_q;

    logic [NUM_REQ*AW_W-1:0]  aw_pack;
    logic [NUM_REQ*W_W-1:0]   w_pack;
    logic [AW_W-1:0]          aw_sel;
    logic [W_W-1:0]           w_sel;
    logic [NUM_REQ-1:0]       awready_vec;
    logic [NUM_REQ-1:0]       wready_vec;
    logic                     sel_ok;
    logic                     last_beat;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     owner_wlast;

    // Per-master payloads packed as {valid, addr, len} and {valid, wlast, strb, data}.
    always_comb begin
        aw_pack     = '0;
        w_pack      = '0;
        awready_vec = '0;
        wready_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aw_pack[i*AW_W +: AW_W] = {bus.m_awvalid[i],
                                       bus.m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                       bus.m_awlen[i*AXI_LEN_WIDTH +: AXI_LEN_WIDTH]};
            w_pack[i*W_W +: W_W]    = {bus.m_wvalid[i], bus.m_wlast[i],
                                       bus.m_wstrb[i*SW +: SW],
                                       bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
            if (owner_q == ID_WIDTH'(i)) begin
                awready_vec[i] = (state_q == ADDR) && bus.s_awready;
                wready_vec[i]  = (state_q == DATA) && bus.s_wready;
            end
        end
    end

    axi_onehot_mux #(.N(NUM_REQ), .W(AW_W), .SEL_W(ID_WIDTH)) u_aw_mux (
        .in_i  (aw_pack),
        .sel_i (owner_q),
        .out_o (aw_sel)
    );

    axi_onehot_mux #(.N(NUM_REQ), .W(W_W), .SEL_W(ID_WIDTH)) u_w_mux (
        .in_i  (w_pack),
        .sel_i (owner_q),
        .out_o (w_sel)
    );

    assign sel_ok      = {1'b0, bus.selected_slave} < NUM_REQ_W;
    assign last_beat   = (beat_cnt_q == '0);
    assign owner_wlast = w_sel[W_W-2];

    assign bus.s_awvalid = (state_q == ADDR) && aw_sel[AW_W-1];
    assign bus.s_awaddr  = aw_sel[AXI_LEN_WIDTH +: ADDR_WIDTH];
    assign bus.s_awlen   = aw_sel[AXI_LEN_WIDTH-1:0];
    assign bus.s_wvalid  = (state_q == DATA) && w_sel[W_W-1];
    assign bus.s_wdata   = w_sel[DATA_WIDTH-1:0];
    assign bus.s_wstrb   = w_sel[DATA_WIDTH +: SW];
    assign bus.s_wlast   = (state_q == DATA) && last_beat;
    assign bus.m_awready = awready_vec;
    assign bus.m_wready  = wready_vec;

    assign aw_hs = bus.s_awvalid && bus.s_awready;
    assign w_hs  = bus.s_wvalid && bus.s_wready;

    assign bus.channel_granted = channel_granted_q;
    assign bus.lock_busy       = lock_busy_q;
    assign bus.owner_id        = owner_q;
    assign bus.sel_err         = sel_err_q;
    assign bus.len_err         = len_err_q;
    assign dbg_state_o         = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            channel_granted_q <= 1'b0;
            lock_busy_q       <= 1'b0;
            sel_err_q         <= 1'b0;
            len_err_q         <= 1'b0;
            owner_q           <= '0;
            beat_cnt_q        <= '0;
        end else begin
            channel_granted_q <= 1'b0;
            sel_err_q         <= 1'b0;
            len_err_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.channel_request) begin
                        if (sel_ok) begin
                            owner_q           <= bus.selected_slave;
                            channel_granted_q <= 1'b1;
                            lock_busy_q       <= 1'b1;
                            state_q           <= ADDR;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        beat_cnt_q <= bus.s_awlen;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        // The master's WLAST is only checked; the slave sees the counter-derived one.
                        if (owner_wlast != last_beat) len_err_q <= 1'b1;
                        if (last_beat) begin
                            state_q     <= IDLE;
                            lock_busy_q <= 1'b0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_path_lock.sv
// Bench for axi_write_path_lock: directed bursts, expected responses queued at issue time
// and popped by an independent monitor whenever the slave side or status outputs fire.
module tb_axi_write_path_lock;
    import axi_ic_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   ready_mode = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    wpl_state_e dbg_state;
    wpl_state_e dbg_state3;

    logic [39:0] aw_q[$];
    logic [36:0] w_q[$];
    logic [0:0]  grant_q[$];
    logic [0:0]  len_q[$];

    axi_write_path_lock_if #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    axi_write_path_lock_if #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    axi_write_path_lock #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    axi_write_path_lock #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut3 (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus3),
        .dbg_state_o (dbg_state3)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input int m, input int b);
        return 32'hD000_0000 + 32'(m << 16) + 32'(b);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_granted"}, bus.channel_granted, 0);
        check({tag, "_lock_busy"}, bus.lock_busy, 0);
        check({tag, "_owner_id"}, bus.owner_id, 0);
        check({tag, "_sel_err"}, bus.sel_err, 0);
        check({tag, "_len_err"}, bus.len_err, 0);
        check({tag, "_m_awready"}, bus.m_awready, 0);
        check({tag, "_m_wready"}, bus.m_wready, 0);
        check({tag, "_s_awvalid"}, bus.s_awvalid, 0);
        check({tag, "_s_wvalid"}, bus.s_wvalid, 0);
        check({tag, "_s_wlast"}, bus.s_wlast, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // Slave model: ready pattern updated just after each rising edge
    initial begin
        bus.s_awready = 1'b0;
        bus.s_wready  = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.s_awready = 1'b1;
            case (ready_mode)
                0:       bus.s_wready = 1'b1;
                1:       bus.s_wready = ~bus.s_wready;
                default: bus.s_wready = 1'b0;
            endcase
        end
    end

    // Driver tasks: all entered and left at posedge+1
    task automatic do_request(input int m);
        bus.channel_request = 1'b1;
        bus.selected_slave  = 1'(m);
        grant_q.push_back(1'(m));
        @(negedge clk);
        check("grant_early", bus.channel_granted, 0);
        @(posedge clk); #1;
        bus.channel_request = 1'b1;
        bus.selected_slave  = 1'(1 - m);
        @(negedge clk);
        check("grant_pulse", bus.channel_granted, 1);
        check("lock_taken", bus.lock_busy, 1);
        check("owner_id", bus.owner_id, m);
        @(posedge clk); #1;
        bus.channel_request = 1'b0;
        @(negedge clk);
        check("grant_one_cycle", bus.channel_granted, 0);
        check("owner_kept", bus.owner_id, m);
        @(posedge clk); #1;
    endtask

    task automatic do_aw(input int m, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 1'b0;
        bus.m_awvalid[m]         = 1'b1;
        bus.m_awaddr[m*AW +: AW] = addr;
        bus.m_awlen[m*8 +: 8]    = len;
        aw_q.push_back({len, addr});
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            ok = bus.m_awready[m];
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL aw_timeout: m_awready[%0d] stayed 0, want 1", m);
        end
        @(posedge clk); #1;
        bus.m_awvalid[m] = 1'b0;
    endtask

    task automatic do_beat(input int m, input logic [31:0] d, input logic [3:0] st,
                           input logic wl, input logic exp_last);
        bit ok = 1'b0;
        bus.m_wvalid[m]         = 1'b1;
        bus.m_wdata[m*DW +: DW] = d;
        bus.m_wstrb[m*4 +: 4]   = st;
        bus.m_wlast[m]          = wl;
        w_q.push_back({st, exp_last, d});
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            ok = bus.m_wready[m];
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL w_timeout: m_wready[%0d] stayed 0, want 1", m);
        end else begin
            check("lock_held_on_beat", bus.lock_busy, 1);
        end
        @(posedge clk); #1;
        bus.m_wvalid[m] = 1'b0;
        bus.m_wlast[m]  = 1'b0;
    endtask

    task automatic run_burst(input int m, input logic [31:0] addr, input int len, input int wlast_beat);
        logic wl;
        logic el;
        do_request(m);
        do_aw(m, addr, 8'(len));
        for (int b = 0; b <= len; b++) begin
            wl = (b >= wlast_beat);
            el = (b == len);
            if (wl != el) len_q.push_back(1'(m));
            do_beat(m, beat_data(m, b), 4'(b) ^ 4'hF, wl, el);
        end
        @(negedge clk);
        check("lock_released", bus.lock_busy, 0);
        check("state_idle_after", dbg_state, IDLE);
        @(posedge clk); #1;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [39:0] ea;
        logic [36:0] ew;
        logic [0:0]  eg;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.s_awvalid && bus.s_awready) begin
                    if (aw_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL aw_extra: got addr 0x%0h, want no AW", bus.s_awaddr);
                    end else begin
                        ea = aw_q.pop_front();
                        check("aw_payload", {bus.s_awlen, bus.s_awaddr}, ea);
                    end
                end
                if (bus.s_wvalid && bus.s_wready) begin
                    if (w_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL w_extra: got data 0x%0h, want no beat", bus.s_wdata);
                    end else begin
                        ew = w_q.pop_front();
                        check("w_beat", {bus.s_wstrb, bus.s_wlast, bus.s_wdata}, ew);
                    end
                end
                if (bus.channel_granted) begin
                    if (grant_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL grant_extra: got grant owner %0d, want none", bus.owner_id);
                    end else begin
                        eg = grant_q.pop_front();
                        check("grant_owner", bus.owner_id, eg);
                    end
                end
                if (bus.len_err) begin
                    if (len_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL len_err_extra: got len_err, want none");
                    end else begin
                        eg = len_q.pop_front();
                        check("len_err_owner", bus.owner_id, eg);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (bus.m_awready[i] || bus.m_wready[i])
                        check("ready_only_owner", {bus.lock_busy, bus.owner_id}, {1'b1, 1'(i)});
                end
            end
        end
    end

    // Main sequence
    initial begin
        bus.channel_request = 1'b0; bus.selected_slave = '0;
        bus.m_awvalid = '0; bus.m_awaddr = '0; bus.m_awlen = '0;
        bus.m_wvalid = '0; bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_wlast = '0;
        bus3.channel_request = 1'b0; bus3.selected_slave = '0;
        bus3.m_awvalid = '0; bus3.m_awaddr = '0; bus3.m_awlen = '0;
        bus3.m_wvalid = '0; bus3.m_wdata = '0; bus3.m_wstrb = '0; bus3.m_wlast = '0;
        bus3.s_awready = 1'b0; bus3.s_wready = 1'b0;

        repeat (2) @(negedge clk);
        check_idle("reset");
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle("post_reset");
        @(posedge clk); #1;

        // Out-of-range selection on the three-master instance
        bus3.channel_request = 1'b1;
        bus3.selected_slave  = 2'd3;
        @(negedge clk);
        check("sel_err_early", bus3.sel_err, 0);
        @(posedge clk); #1;
        bus3.channel_request = 1'b0;
        @(negedge clk);
        check("sel_err_pulse", bus3.sel_err, 1);
        check("sel_err_no_grant", bus3.channel_granted, 0);
        check("sel_err_no_lock", bus3.lock_busy, 0);
        check("sel_err_state", dbg_state3, IDLE);
        @(posedge clk); #1;
        @(negedge clk);
        check("sel_err_one_cycle", bus3.sel_err, 0);
        @(posedge clk); #1;

        ready_mode = 0;
        run_burst(1, 32'h1000_0040, 3, 3);

        ready_mode = 1;
        run_burst(1, 32'h2000_0080, 3, 3);

        ready_mode = 0;
        run_burst(0, 32'h3000_0100, 2, 1);

        // Reset while beat 2 of an 8-beat burst is pending
        do_request(1);
        do_aw(1, 32'h4000_0000, 8'd7);
        do_beat(1, beat_data(1, 0), 4'hF, 1'b0, 1'b0);
        ready_mode = 2;
        bus.m_wvalid[1]          = 1'b1;
        bus.m_wdata[1*DW +: DW]  = beat_data(1, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_idle("mid_burst_reset");
        bus.m_wvalid[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        #3 reset_n = 1'b1;
        ready_mode = 0;
        @(posedge clk); #1;
        run_burst(0, 32'h5000_0000, 0, 0);

        run_burst(1, 32'h6000_0000, 255, 255);

        repeat (4) @(posedge clk);
        #1;
        check("aw_q_drained", aw_q.size(), 0);
        check("w_q_drained", w_q.size(), 0);
        check("grant_q_drained", grant_q.size(), 0);
        check("len_q_drained", len_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_write_path_lock.md
Name: axi_write_path_lock

Overview:
Downstream stage of the write-address arbiter. It consumes the arbiter's channel_request/selected_slave decision and returns channel_granted. It then locks the single slave-side AW+W path to the chosen master for exactly one burst, generating WLAST from a beat counter. The lock releases after the final W beat, and the block returns to accepting the next arbitration result.

Parameters:
NUM_REQ, 2, number of requesting masters
ID_WIDTH, $clog2(NUM_REQ), width of the master index
ADDR_WIDTH, 32, AW address width
DATA_WIDTH, 32, W data width (WSTRB is DATA_WIDTH/8)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
channel_request  input  1  arbiter has a valid winner
selected_slave  input  ID_WIDTH  index of the winning master
channel_granted  output  1  one-cycle pulse: request accepted, lock taken
lock_busy  output  1  path currently owned
owner_id  output  ID_WIDTH  current owner index
m_awvalid  input  NUM_REQ  per-master AWVALID
m_awready  output  NUM_REQ  per-master AWREADY
m_awaddr  input  NUM_REQ*ADDR_WIDTH  per-master AWADDR
m_awlen  input  NUM_REQ*8  per-master AWLEN
m_wvalid  input  NUM_REQ  per-master WVALID
m_wready  output  NUM_REQ  per-master WREADY
m_wdata  input  NUM_REQ*DATA_WIDTH  per-master WDATA
m_wstrb  input  NUM_REQ*DATA_WIDTH/8  per-master WSTRB
m_wlast  input  NUM_REQ  per-master WLAST (checked, not forwarded)
s_awvalid/s_awaddr/s_awlen  output  1/ADDR_WIDTH/8  slave AW
s_awready  input  1  slave AWREADY
s_wvalid/s_wdata/s_wstrb/s_wlast  output  1/DATA_WIDTH/DATA_WIDTH/8/1  slave W
s_wready  input  1  slave WREADY
sel_err  output  1  one-cycle pulse: selected_slave >= NUM_REQ
len_err  output  1  one-cycle pulse: master WLAST disagrees with beat count

Behaviour:
- Reset (asynchronous, active-low): state IDLE. channel_granted, lock_busy, owner_id, sel_err, len_err and beat counter are 0. All m_*ready and s_*valid are 0. Reset mid-burst abandons the burst with no recovery.
- FSM states: IDLE, ADDR, DATA.
- IDLE, channel_request=1, selected_slave<NUM_REQ:
  - register owner_id=selected_slave.
  - next cycle: channel_granted=1 for exactly one cycle, lock_busy=1, state ADDR.
- IDLE, channel_request=1, selected_slave>=NUM_REQ: sel_err pulses 1 cycle; no grant; stay IDLE.
- channel_request is ignored while lock_busy=1.
- ADDR:
  - s_awvalid/addr/len are a combinational mux of the owner's AW inputs.
  - m_awready[owner]=s_awready; all other m_awready are 0.
  - On AW handshake: beat_cnt<=awlen, state DATA.
  - W is blocked (all m_wready=0, s_wvalid=0) until AW completes.
- DATA:
  - s_wvalid/wdata/wstrb are muxed from the owner.
  - m_wready[owner]=s_wready; others are 0.
  - s_wlast=(beat_cnt==0), generated locally.
  - On each W handshake:
    - if m_wlast[owner] != (beat_cnt==0), pulse len_err next cycle.
    - if beat_cnt==0: state IDLE, lock_busy=0.
    - else: beat_cnt-1.
- Latency: request-to-grant 1 cycle. AW and W are combinational pass-through (0 latency). There is at least one IDLE cycle between bursts.
- AWLEN=0 gives a single-beat burst with s_wlast high on the first beat. AWLEN=255 gives 256 beats; the counter is 8 bits with no wrap.
- Slave backpressure: valid/data stay stable via the master holding them. The lock never releases without the final handshake.
- Non-owner masters never see ready=1 while the lock is held.

Decomposition:
- Shared package axi_ic_pkg holds:
  - state enum wpl_state_e {IDLE, ADDR, DATA}.
  - AXI_LEN_WIDTH=8.
  - STRB_WIDTH function (DATA_WIDTH/8).
- One natural sub-module, axi_onehot_mux, a parameterised index-select mux reused for the AW and W payloads.
- FSM and counter stay in the top.

Test Plan:
- Reset then idle: all outputs 0. channel_request=1, selected=1 -> channel_granted pulses exactly at cycle+1, owner_id=1, lock_busy=1.
- Master1 AWLEN=3, s_awready=1, s_wready=1 every cycle -> 4 W beats forwarded, s_wlast only on beat 4, lock_busy drops the cycle after beat 4, m_wready[0] never 1.
- Same burst with s_wready toggling 1,0,1,0 -> still exactly 4 handshakes, data order preserved, no early release.
- Master0 AWLEN=2 with m_wlast asserted on beat 2 -> len_err pulses once. Third beat still accepted with s_wlast=1, then IDLE.
- NUM_REQ=3, selected_slave=3 with channel_request=1 -> sel_err pulse, no channel_granted, stays IDLE.
- reset_n low during DATA beat 2 of 8 -> all outputs 0 immediately. After release, a new request with AWLEN=0 completes a single-beat burst normally.
